// File: rtl/fft_out_collector.sv
`default_nettype none
// ============================================================================
// Module      : fft_out_collector
// Description : Captures FFT output frames into a ping-pong buffer and drains
//               them as a one-complex-sample-per-beat valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_out_collector #(
    parameter int WIDTH       = 32,
    parameter int LANES       = 8,
    parameter int FRAME_BEATS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             next_out,
    input  logic [WIDTH-1:0] y [0:2*LANES-1],
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_re,
    output logic [WIDTH-1:0] m_im,
    output logic             m_last,
    output logic [1:0]       pending,
    output logic             ovf,
    output logic             proto_err,
    input  logic             err_clr
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BCNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    localparam logic [BCNT_W-1:0] c_last_beat = BCNT_W'(FRAME_BEATS - 1);
    localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(LANES - 1);

    localparam logic [0:0] c_cst_idle = 1'b0;
    localparam logic [0:0] c_cst_cap  = 1'b1;
    localparam logic [0:0] c_dst_idle = 1'b0;
    localparam logic [0:0] c_dst_send = 1'b1;

    logic [2*WIDTH-1:0] r_mem [0:1][0:FRAME_BEATS-1][0:LANES-1];

    logic [0:0]        r_cstate;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_wsel;
    logic [1:0]        r_full;
    logic              r_ovf;
    logic              r_proto_err;
    logic [1:0]        r_pending;

    logic [0:0]        r_dstate;
    logic              r_rsel;
    logic [BCNT_W-1:0] r_sbeat;
    logic [LANE_W-1:0] r_slane;
    logic [WIDTH-1:0]  r_m_re;
    logic [WIDTH-1:0]  r_m_im;
    logic              r_m_last;

    logic              w_cap_done;
    logic              w_hs;
    logic              w_rel;
    logic [1:0]        w_set;
    logic [1:0]        w_clr;
    logic [1:0]        w_full_n;
    logic [1:0]        w_full_eff;
    logic [1:0]        w_free;
    logic              w_ovf_set;
    logic              w_proto_set;

    logic              w_load;
    logic              w_rd_bank;
    logic [BCNT_W-1:0] w_rd_beat;
    logic [LANE_W-1:0] w_rd_lane;
    logic              w_rsel_n;
    logic [0:0]        w_dstate_n;
    logic              w_byp;
    logic [2*WIDTH-1:0] w_rd_word;

    // Bank bookkeeping: a bank released by this cycle's final handshake is
    // already free for a frame starting this cycle.
    always_comb begin
        w_cap_done  = (r_cstate == c_cst_cap) && (r_bcnt == c_last_beat);
        w_hs        = (r_dstate == c_dst_send) && m_ready;
        w_rel       = w_hs && r_m_last;
        w_set       = w_cap_done ? (2'b01 << r_wsel) : 2'b00;
        w_clr       = w_rel ? (2'b01 << r_rsel) : 2'b00;
        w_full_n    = (r_full | w_set) & ~w_clr;
        w_full_eff  = r_full | w_set;
        w_free      = ~r_full | w_clr;
        w_ovf_set   = next_out &&
                      (((r_cstate == c_cst_idle) && !w_free[r_wsel]) ||
                       (w_cap_done && !w_free[~r_wsel]));
        w_proto_set = next_out && (r_cstate == c_cst_cap) && !w_cap_done;
    end

    always_ff @(posedge clk) begin
        if (r_cstate == c_cst_cap) begin
            for (int k = 0; k < LANES; k++) begin
                r_mem[r_wsel][r_bcnt][k[LANE_W-1:0]] <=
                    {y[{k[LANE_W-1:0], 1'b0}], y[{k[LANE_W-1:0], 1'b1}]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cstate    <= c_cst_idle;
            r_bcnt      <= '0;
            r_wsel      <= 1'b0;
            r_full      <= 2'b00;
            r_ovf       <= 1'b0;
            r_proto_err <= 1'b0;
            r_pending   <= 2'd0;
        end else begin
            r_full      <= w_full_n;
            r_pending   <= {1'b0, w_full_n[0]} + {1'b0, w_full_n[1]};
            r_ovf       <= (r_ovf & ~err_clr) | w_ovf_set;
            r_proto_err <= (r_proto_err & ~err_clr) | w_proto_set;
            case (r_cstate)
                c_cst_idle: begin
                    if (next_out && w_free[r_wsel]) begin
                        r_cstate <= c_cst_cap;
                        r_bcnt   <= '0;
                    end
                end
                default: begin
                    if (w_cap_done) begin
                        r_wsel   <= ~r_wsel;
                        r_bcnt   <= '0;
                        r_cstate <= (next_out && w_free[~r_wsel]) ? c_cst_cap : c_cst_idle;
                    end else begin
                        r_bcnt <= r_bcnt + BCNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Next sample to present; a frame completing this cycle is visible to the
    // drain side immediately so the first sample leaves without a bubble.
    always_comb begin
        w_load     = 1'b0;
        w_rd_bank  = r_rsel;
        w_rd_beat  = r_sbeat;
        w_rd_lane  = r_slane;
        w_rsel_n   = r_rsel;
        w_dstate_n = r_dstate;
        case (r_dstate)
            c_dst_idle: begin
                if (w_full_eff[r_rsel]) begin
                    w_load     = 1'b1;
                    w_rd_beat  = '0;
                    w_rd_lane  = '0;
                    w_dstate_n = c_dst_send;
                end
            end
            default: begin
                if (w_hs) begin
                    if (r_m_last) begin
                        w_rsel_n  = ~r_rsel;
                        w_rd_bank = ~r_rsel;
                        w_rd_beat = '0;
                        w_rd_lane = '0;
                        if (w_full_eff[~r_rsel]) begin
                            w_load = 1'b1;
                        end else begin
                            w_dstate_n = c_dst_idle;
                        end
                    end else if (r_slane == c_last_lane) begin
                        w_load    = 1'b1;
                        w_rd_beat = r_sbeat + BCNT_W'(1);
                        w_rd_lane = '0;
                    end else begin
                        w_load    = 1'b1;
                        w_rd_lane = r_slane + LANE_W'(1);
                    end
                end
            end
        endcase
    end

    // The beat being written right now has not reached the buffer yet.
    always_comb begin
        w_byp     = (r_cstate == c_cst_cap) && (r_wsel == w_rd_bank) && (r_bcnt == w_rd_beat);
        w_rd_word = w_byp ? {y[{w_rd_lane, 1'b0}], y[{w_rd_lane, 1'b1}]}
                          : r_mem[w_rd_bank][w_rd_beat][w_rd_lane];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dstate <= c_dst_idle;
            r_rsel   <= 1'b0;
            r_sbeat  <= '0;
            r_slane  <= '0;
            r_m_re   <= '0;
            r_m_im   <= '0;
            r_m_last <= 1'b0;
        end else begin
            r_dstate <= w_dstate_n;
            r_rsel   <= w_rsel_n;
            if (w_load) begin
                r_sbeat  <= w_rd_beat;
                r_slane  <= w_rd_lane;
                r_m_re   <= w_rd_word[2*WIDTH-1:WIDTH];
                r_m_im   <= w_rd_word[WIDTH-1:0];
                r_m_last <= (w_rd_beat == c_last_beat) && (w_rd_lane == c_last_lane);
            end else if (w_dstate_n == c_dst_idle) begin
                r_m_last <= 1'b0;
            end
        end
    end

    assign m_valid   = (r_dstate == c_dst_send);
    assign m_re      = r_m_re;
    assign m_im      = r_m_im;
    assign m_last    = r_m_last;
    assign pending   = r_pending;
    assign ovf       = r_ovf;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_out_collector
// Description : Self-checking bench for fft_out_collector (FRAME_BEATS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_out_collector;

    localparam int W  = 32;
    localparam int LN = 8;
    localparam int FB = 2;
    localparam int NS = FB * LN;

    logic          clk = 1'b0;
    logic          reset;
    logic          next_out;
    logic [W-1:0]  y [0:2*LN-1];
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_re;
    logic [W-1:0]  m_im;
    logic          m_last;
    logic [1:0]    pending;
    logic          ovf;
    logic          proto_err;
    logic          err_clr;

    fft_out_collector #(.WIDTH(W), .LANES(LN), .FRAME_BEATS(FB)) dut (
        .clk(clk), .reset(reset), .next_out(next_out), .y(y),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_last(m_last), .pending(pending), .ovf(ovf), .proto_err(proto_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int held     = 0;
    int hs_count = 0;
    int first_hs = 0;
    int last_hs  = 0;
    bit rand_ready = 1'b0;

    logic [W-1:0] frm [0:2][0:FB-1][0:2*LN-1];
    logic [2*W:0] exp_q [$];

    logic         prev_stall = 1'b0;
    logic [W-1:0] p_re, p_im;
    logic         p_last;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted sample must be the next one the model owes.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            check("pending_max", {95'd0, pending > 2'd2}, 96'd0);
            if (prev_stall)
                check("stall_hold", {m_valid, m_re, m_im, m_last}, {1'b1, p_re, p_im, p_last});
            if (m_valid && m_ready) begin
                check("unexpected_sample", {95'd0, exp_q.size() == 0}, 96'd0);
                if (exp_q.size() != 0) begin
                    logic [2*W:0] e;
                    e = exp_q.pop_front();
                    check("sample", {m_re, m_im, m_last}, e);
                    hs_count++;
                    if (hs_count == 1) first_hs = cyc;
                    last_hs = cyc;
                    if (e[0]) held--;
                end
            end
            prev_stall = m_valid && !m_ready;
            p_re   = m_re;
            p_im   = m_im;
            p_last = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic gen_pattern(input int slot, input int base);
        for (int b = 0; b < FB; b++)
            for (int k = 0; k < 2 * LN; k++)
                frm[slot][b][k] = W'(base + 100 * b + k);
    endtask

    task automatic gen_random(input int slot);
        for (int b = 0; b < FB; b++)
            for (int k = 0; k < 2 * LN; k++)
                frm[slot][b][k] = $urandom;
    endtask

    // A frame is kept only if fewer than two frames are held downstream.
    task automatic note_strobe(input int slot);
        if (held < 2) begin
            held++;
            for (int s = 0; s < NS; s++)
                exp_q.push_back({frm[slot][s / LN][2 * (s % LN)],
                                 frm[slot][s / LN][2 * (s % LN) + 1], s == NS - 1});
        end
    endtask

    task automatic set_beat(input int slot, input int b);
        for (int k = 0; k < 2 * LN; k++) y[k] = frm[slot][b][k];
    endtask

    task automatic strobe(input int slot);
        next_out = 1'b1;
        note_strobe(slot);
    endtask

    task automatic beats(input int slot, input bit strobe_last, input int nslot);
        for (int b = 0; b < FB; b++) begin
            tick();
            set_beat(slot, b);
            next_out = 1'b0;
            if (strobe_last && b == FB - 1) begin
                next_out = 1'b1;
                note_strobe(nslot);
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        check(tag, 96'(exp_q.size()), 96'd0);
        tick();
        tick();
        check({tag, "_pending"}, {94'd0, pending}, 96'd0);
        check({tag, "_valid"}, {95'd0, m_valid}, 96'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        held = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; next_out = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        for (int k = 0; k < 2 * LN; k++) y[k] = '0;
        repeat (3) tick();
        check("rst_outputs", {m_valid, m_last, pending, ovf, proto_err}, 96'd0);
        check("rst_data", {m_re, m_im}, 96'd0);
        reset = 1'b1;
        tick();

        // Single frame with the y[k] = 100*beat + k pattern
        m_ready = 1'b1;
        gen_pattern(0, 0);
        strobe(0);
        beats(0, 1'b0, 0);
        check("first_not_early", {95'd0, m_valid}, 96'd0);
        tick();
        check("first_latency", {m_valid, m_re, m_im}, {1'b1, 32'd0, 32'd1});
        wait_drain("single");

        // Back-to-back frames, second strobe on the last beat of the first
        gen_pattern(0, 1000);
        gen_pattern(1, 2000);
        hs_count = 0;
        strobe(0);
        beats(0, 1'b1, 1);
        beats(1, 1'b0, 0);
        tick();
        wait_drain("b2b");
        check("b2b_count", 96'(hs_count), 96'd32);
        check("b2b_span", 96'(last_hs - first_hs), 96'd31);
        check("b2b_errs", {ovf, proto_err}, 96'd0);

        // Random backpressure over three random frames
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 400 && held >= 2; i++) tick();
            check("bp_wait", {95'd0, held >= 2}, 96'd0);
            gen_random(f);
            strobe(f);
            beats(f, 1'b0, 0);
            tick();
            next_out = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain("bp");
        rand_ready = 1'b0;
        check("bp_errs", {ovf, proto_err}, 96'd0);

        // Overflow: three frames with the sink stalled
        m_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            gen_pattern(f, 3000 + 1000 * f);
            strobe(f);
            beats(f, 1'b0, 0);
            tick();
            tick();
        end
        check("ovf_set", {ovf, pending}, {1'b1, 2'd2});
        m_ready = 1'b1;
        wait_drain("ovf_drain");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clear", {95'd0, ovf}, 96'd0);

        // Protocol error: stray strobe on beat 0
        gen_pattern(0, 6000);
        strobe(0);
        tick();
        set_beat(0, 0);
        next_out = 1'b1;
        tick();
        set_beat(0, 1);
        next_out = 1'b0;
        tick();
        check("proto_set", {ovf, proto_err}, {1'b0, 1'b1});
        wait_drain("proto_drain");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("proto_clear", {95'd0, proto_err}, 96'd0);

        // Reset on the second beat of a capture while a frame is buffered
        m_ready = 1'b0;
        gen_pattern(0, 7000);
        strobe(0);
        beats(0, 1'b0, 0);
        tick();
        next_out = 1'b0;
        check("rst1_pre", {m_valid, pending}, {1'b1, 2'd1});
        gen_pattern(1, 8000);
        strobe(1);
        beats(1, 1'b0, 0);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst1_drop", {m_valid, pending}, 96'd0);
        next_out = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Reset while a frame is draining
        m_ready = 1'b1;
        gen_pattern(2, 9000);
        strobe(2);
        beats(2, 1'b0, 0);
        repeat (5) tick();
        next_out = 1'b0;
        check("rst2_pre", {95'd0, m_valid}, 96'd1);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst2_drop", {m_valid, pending}, 96'd0);
        tick();
        reset = 1'b1;
        tick();

        // Fresh frame after reset
        gen_random(0);
        strobe(0);
        beats(0, 1'b0, 0);
        tick();
        next_out = 1'b0;
        wait_drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_out_collector.md
# fft_out_collector

Receive-side companion to the streaming FFT core. It watches the core's `next_out` strobe and captures each output frame (8 complex points per beat) into a two-frame ping-pong buffer. It then drains the frame as a valid/ready stream of one complex sample per beat, so downstream logic (accumulation, IFFT feed, host DMA) can apply backpressure that the FFT core itself cannot accept.

## Interface
- `WIDTH`, 32, bits per real or imaginary word.
- `LANES`, 8, complex points per FFT output beat; the FFT output bus carries 2·LANES words.
- `FRAME_BEATS`, 1, consecutive beats per FFT frame; legal range 1..16.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `next_out`  in  1  one-cycle strobe from the FFT; frame beat 0 is on `y` in the following cycle.
- `y[0:2*LANES-1]`  in  WIDTH each  FFT output words; lane k is `y[2k]` + j·`y[2k+1]`.
- `m_valid`  out  1  output sample valid.
- `m_ready`  in  1  downstream accepts the sample.
- `m_re`, `m_im`  out  WIDTH  real and imaginary parts of the current sample.
- `m_last`  out  1  high on the final sample of a frame (index FRAME_BEATS·LANES−1).
- `pending`  out  2  number of complete frames buffered (0..2).
- `ovf`  out  1  sticky flag: a frame was dropped because no buffer was free.
- `proto_err`  out  1  sticky flag: `next_out` arrived mid-capture.
- `err_clr`  in  1  synchronous clear of `ovf` and `proto_err`.

## Operation
- Storage: 2 banks × FRAME_BEATS × LANES complex entries, each 2·WIDTH bits. Banks have per-bank `full` flags, plus a write-bank pointer `wsel` and a read-bank pointer `rsel`.
- Capture FSM:
  - C_IDLE: on `next_out`, go to C_CAP if the bank at `wsel` is free. Otherwise set `ovf`, stay in C_IDLE, and ignore that frame's beats.
  - C_CAP: each cycle, write all LANES points of `y` into bank `wsel`, beat index `bcnt`, then increment `bcnt`.
  - On beat FRAME_BEATS−1: set `full[wsel]`, toggle `wsel`, clear `bcnt`. If `next_out` is also high that cycle (back-to-back frames), re-enter C_CAP under the same free-bank check. Otherwise return to C_IDLE.
  - `next_out` on any other C_CAP cycle: set `proto_err`; the capture in progress continues unaffected.
- Drain FSM:
  - D_IDLE: when `full[rsel]` is set, go to D_SEND with sample index `scnt` = 0.
  - D_SEND: present entry `scnt` of bank `rsel`. Order is beat-major, lane-minor: beat 0 lane 0, beat 0 lane 1, …
  - On each handshake (`m_valid` && `m_ready`), increment `scnt`.
  - On the handshake with `m_last`: clear `full[rsel]`, toggle `rsel`, then go to D_SEND with `scnt` = 0 if the other bank is full, else D_IDLE.
- Simultaneous events:
  - A bank released by the final handshake in the same cycle as `next_out` counts as free, so no overflow is flagged.
  - Set and clear of `pending` in the same cycle leaves the count unchanged.
  - `err_clr` and a new error in the same cycle: the flag ends up set.
- Data is passed through unchanged; there is no arithmetic or rescaling.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_re`=`m_im`=0, `pending`=0, `ovf`=0, `proto_err`=0. Both FSMs idle, all pointers 0, `full` flags cleared.
- Reset mid-operation discards any partial capture and all buffered frames. `m_valid` drops as soon as `reset` goes low.
- Capture latency: with `next_out` at cycle t, beats are sampled at t+1 … t+FRAME_BEATS.
- First sample: `m_valid` rises at t+FRAME_BEATS+1.
- The stream is registered. `m_re`, `m_im` and `m_last` are stable while `m_valid` is high and `m_ready` is low.
- With `m_ready` held high, a frame drains in FRAME_BEATS·LANES cycles with no bubbles. The next buffered frame follows with zero idle cycles.
- `pending` updates one cycle after the frame-complete or release event.

## Test plan
- Single frame (FRAME_BEATS=2, LANES=8): `next_out`, then `y[k]` = 100·beat+k.
  - Samples 0..15 appear from t+3.
  - Sample 9 = (102, 103); sample 15 = (114, 115), with `m_last` high.
- Back-to-back: 2nd `next_out` on the last beat of frame 1, `m_ready`=1.
  - `proto_err`=0 and `ovf`=0.
  - 32 contiguous samples; `m_last` on samples 15 and 31.
- Backpressure: random 50% `m_ready` over 3 frames.
  - Order is preserved and values are stable while stalled.
  - `pending` never exceeds 2.
- Overflow: `m_ready`=0, three frames.
  - `pending`=2 and `ovf`=1.
  - After releasing `m_ready`, only frames 1 and 2 emerge.
  - `err_clr` returns `ovf` to 0.
- Protocol error: `next_out` on beat 0 of a 2-beat capture.
  - `proto_err`=1 and the frame is still captured intact.
- Reset: drive `reset`=0 on the second beat of a capture and while a frame is draining.
  - `m_valid`=0 and `pending`=0 immediately.
  - A fresh frame after reset drains correctly.
